// File: rtl/hd_entry_ctrl.sv
// Board-input front end: synchronises and debounces the hex keys and buttons,
// assembles hex digits into an entry register and drives the CPU clock enable.
module hd_entry_ctrl #(
    parameter int N_KEYS      = 16,
    parameter int DATA_W      = 32,
    parameter int DB_CYCLES   = 4,
    parameter int STEP_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_KEYS-1:0]           hd,
    input  logic                        ent,
    input  logic                        chk,
    input  logic                        step,
    output logic [DATA_W-1:0]           data_out,
    output logic                        data_valid,
    output logic [DATA_W-1:0]           entry,
    output logic [$clog2(DATA_W/4):0]   digit_cnt,
    output logic                        ovf,
    output logic                        cpu_en
);

    localparam int NIN      = N_KEYS + 3;
    localparam int IDX_ENT  = N_KEYS;
    localparam int IDX_CHK  = N_KEYS + 1;
    localparam int IDX_STEP = N_KEYS + 2;
    localparam int DBW      = $clog2(DB_CYCLES + 1);
    localparam int CNTW     = $clog2(DATA_W / 4) + 1;
    localparam int MAXD     = DATA_W / 4;
    localparam int STW      = $clog2(STEP_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    logic [NIN-1:0]    raw;
    logic [NIN-1:0]    sync1;
    logic [NIN-1:0]    sync2;
    logic [NIN-1:0]    db_lvl;
    logic [NIN-1:0]    db_prev;
    logic [NIN-1:0]    rise;
    logic [DBW-1:0]    db_cnt [NIN];

    logic              key_hit;
    logic [3:0]        key_digit;

    logic [1:0]        state;
    logic [STW-1:0]    burst_cnt;
    logic              chk_lvl;
    logic              step_rise;

    assign raw = {step, chk, ent, hd};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level flips only after DB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_lvl <= '0;
            for (int i = 0; i < NIN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                        db_lvl[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_prev <= '0;
            rise    <= '0;
        end else begin
            db_prev <= db_lvl;
            rise    <= db_lvl & ~db_prev;
        end
    end

    // Descending scan so the lowest pressed key ends up selected.
    always_comb begin
        key_hit   = 1'b0;
        key_digit = 4'd0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                key_hit   = 1'b1;
                key_digit = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            entry      <= '0;
            digit_cnt  <= '0;
            ovf        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (rise[IDX_ENT]) begin
                data_out   <= entry;
                data_valid <= 1'b1;
                entry      <= '0;
                digit_cnt  <= '0;
                ovf        <= 1'b0;
            end else if (key_hit) begin
                entry <= (entry << 4) | DATA_W'(key_digit);
                if (digit_cnt == CNTW'(MAXD)) begin
                    ovf <= 1'b1;
                end else begin
                    digit_cnt <= digit_cnt + 1'b1;
                end
            end
        end
    end

    assign chk_lvl   = db_prev[IDX_CHK];
    assign step_rise = rise[IDX_STEP];

    // A low mode switch forces RUN from any state; a high one parks RUN in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
        end else if (!chk_lvl) begin
            state     <= S_RUN;
            burst_cnt <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    if (step_rise) begin
                        state     <= S_BURST;
                        burst_cnt <= STW'(STEP_CYCLES - 1);
                    end
                end
                S_BURST: begin
                    if (burst_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        burst_cnt <= burst_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_en = (state == S_RUN) || (state == S_BURST);

endmodule
